alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Sequential front-end that drives the team's 8-bit combinational ALU: operands A/B, 3-bit opcode; returns Result and Zero flag.
- Accepts operation commands over a valid/ready request channel, registers and drives the ALU operand/opcode inputs, waits a fixed settle time, then captures Result/Zero.
- Returns each outcome on a valid/ready response channel.
- Sits between a command source (sequencer or bus bridge) and the ALU instance in the parent.

Parameters:
- DATA_W, 8: operand/result width; must match the ALU.
- SETTLE_CYC, 1: cycles from driving alu_* to capturing alu_result; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor; 110/111 invalid.
- cmd_chain  in  1  use last result as A (only with RESULT_CHAIN_EN).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_result  out  DATA_W  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  command rejected (invalid opcode).
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_opcode  out  3  to ALU opcode.
- alu_result  in  DATA_W  from ALU.
- alu_zero  in  1  from ALU.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 except cmd_ready=1.
  - Settle counter and last_result cleared to 0.
  - An in-flight command is dropped; no response is produced for it.
- States:
  - IDLE: cmd_ready=1.
    - Handshake (cmd_valid&cmd_ready) with opcode 000..101: register alu_a/alu_b/alu_opcode; cnt=SETTLE_CYC-1; go to WAIT.
    - Handshake with opcode 110/111: go to RESP with rsp_err=1, rsp_result=0, rsp_zero=0; alu_* unchanged.
  - WAIT: cmd_ready=0.
    - cnt!=0: decrement.
    - cnt==0: capture alu_result→rsp_result and alu_zero→rsp_zero; rsp_err=0; update last_result; go to RESP.
  - RESP: rsp_valid=1, cmd_ready=0.
    - On rsp_ready: go to IDLE; rsp_valid drops the next cycle.
- Latency:
  - Valid command accepted at edge k: rsp_valid high after edge k+SETTLE_CYC.
  - Invalid command accepted at edge k: rsp_valid high after edge k.
  - Back-to-back throughput: one command per SETTLE_CYC+2 cycles when rsp_ready is held high.
- cmd_ready is a function of state only; it never depends combinationally on cmd_valid.
- rsp_result/rsp_zero/rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- alu_* hold the last issued values in IDLE and RESP; they are never cleared except by reset.
- Arithmetic (add/sub wrap modulo 2^DATA_W, zero flag) is performed in the ALU; the issuer does no arithmetic except the counter.
- Only one command is outstanding at a time; no queuing.

Optional Feature:
- Macro RESULT_CHAIN_EN.
- Defined:
  - Handshake with cmd_chain=1 drives alu_a from last_result instead of cmd_a.
  - last_result is updated only on non-error captures.
  - cmd_chain is ignored for invalid opcodes.
- Undefined:
  - cmd_chain is ignored, last_result logic is absent, and alu_a always comes from cmd_a.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_NOR).
  - function op_is_valid(op).
  - issuer state enum {IDLE, WAIT, RESP}.
  - DATA_W default constant.
- No sub-module: the settle counter is inline. The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Add, no chain: A=8, B=4, op=000, SETTLE_CYC=1, rsp_ready=1 → alu_a=8, alu_b=4 after accept; rsp_result=12, rsp_zero=0, rsp_err=0; rsp_valid one edge after accept.
- Subtract and add wrap:
  - A=8, B=8, op=001 → result 0, zero=1.
  - A=255, B=1, op=000 → result 0, zero=1.
  - NOR A=8, B=4 → 0xF3, zero=0.
- Invalid opcode: op=110 → rsp_valid after the accept edge, rsp_err=1, rsp_result=0, rsp_zero=0; alu_opcode keeps its prior value.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → response fields stable, cmd_ready=0, busy=1; a new cmd_valid is not accepted until one cycle after rsp_ready=1.
- Settle latency and reset:
  - With SETTLE_CYC=3, rsp_valid rises exactly 3 edges after accept.
  - rst_n pulsed low during WAIT → all outputs 0, cmd_ready=1, no rsp_valid for the dropped command.
- RESULT_CHAIN_EN: add 8+4 (→12), then cmd_chain=1, op=000, cmd_a=99, cmd_b=4 → alu_a=12, result 16. Without the macro, the same stimulus gives 103.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode encodings,
// opcode legality check, issuer state encoding and default data width.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } issuer_state_e;

  // Opcodes 110/111 have no ALU function and are answered with an error.
  function automatic logic op_is_valid(input logic [2:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Sequential front-end for the combinational ALU: accepts a command on a
// valid/ready channel, drives the ALU inputs, waits SETTLE_CYC cycles,
// captures result/zero and returns them on a valid/ready response channel.
// Optional build macro RESULT_CHAIN_EN: cmd_chain=1 feeds the last
// captured result into ALU operand A instead of cmd_a.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_chain,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  // Settle counter is 4 bits wide, enough for SETTLE_CYC up to 15.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  issuer_state_e     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef RESULT_CHAIN_EN
  logic [DATA_W-1:0] last_result_q, last_result_d;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
`endif

  // Handshake outputs depend on state only.
  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

  // Next-state logic: accept, settle countdown, capture, response hold.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
`ifdef RESULT_CHAIN_EN
    last_result_d = last_result_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (op_is_valid(cmd_op)) begin
`ifdef RESULT_CHAIN_EN
            alu_a_d = cmd_chain ? last_result_q : cmd_a;
`else
            alu_a_d = cmd_a;
`endif
            alu_b_d  = cmd_b;
            alu_op_d = cmd_op;
            cnt_d    = CNT_INIT;
            state_d  = WAIT;
          end else begin
            // Rejected command leaves the ALU inputs untouched.
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            state_d      = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = 1'b0;
`ifdef RESULT_CHAIN_EN
          last_result_d = alu_result;
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef RESULT_CHAIN_EN
      last_result_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
`ifdef RESULT_CHAIN_EN
      last_result_q <= last_result_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: one instance with SETTLE_CYC=1 and one
// with SETTLE_CYC=3, each wired to a behavioural ALU.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       c_valid1, c_valid3, rsp_ready, cmd_chain;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;

  logic       cmd_ready1, rsp_valid1, rsp_zero1, rsp_err1, busy1, alu_zero1;
  logic [7:0] rsp_result1, alu_a1, alu_b1, alu_res1;
  logic [2:0] alu_op1;
  logic       cmd_ready3, rsp_valid3, rsp_zero3, rsp_err3, busy3, alu_zero3;
  logic [7:0] rsp_result3, alu_a3, alu_b3, alu_res3;
  logic [2:0] alu_op3;

  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a | b);
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), r};
  endfunction

  assign {alu_zero1, alu_res1} = alu_model(alu_a1, alu_b1, alu_op1);
  assign {alu_zero3, alu_res3} = alu_model(alu_a3, alu_b3, alu_op3);

  alu_cmd_issuer #(.DATA_W(8), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
    .rsp_zero(rsp_zero1), .rsp_err(rsp_err1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_opcode(alu_op1), .alu_result(alu_res1), .alu_zero(alu_zero1), .busy(busy1)
  );

  alu_cmd_issuer #(.DATA_W(8), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_err(rsp_err3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_opcode(alu_op3), .alu_result(alu_res3), .alu_zero(alu_zero3), .busy(busy3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic ch);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch; c_valid1 = 1'b1;
    tick();
    c_valid1 = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = 1'b0; c_valid3 = 1'b1;
    tick();
    c_valid3 = 1'b0;
  endtask

  // Reset: everything 0 except cmd_ready (MSB of the packed vector).
  task automatic test_reset;
    logic [31:0] v1, v3;
    #1;
    v1 = {cmd_ready1, rsp_valid1, busy1, rsp_err1, rsp_zero1, rsp_result1, alu_a1, alu_b1, alu_op1};
    v3 = {cmd_ready3, rsp_valid3, busy3, rsp_err3, rsp_zero3, rsp_result3, alu_a3, alu_b3, alu_op3};
    checks++;
    if (v1 !== 32'h8000_0000) begin
      errors++; $display("FAIL reset_dut1 got %h exp 80000000", v1);
    end
    checks++;
    if (v3 !== 32'h8000_0000) begin
      errors++; $display("FAIL reset_dut3 got %h exp 80000000", v3);
    end
  endtask

  task automatic test_add;
    send1(8'd8, 8'd4, 3'b000, 1'b0);
    checks++;
    if ({alu_a1, alu_b1, alu_op1, rsp_valid1, busy1} !== {8'd8, 8'd4, 3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_issue got a=%0d b=%0d op=%0d v=%b busy=%b exp a=8 b=4 op=0 v=0 busy=1",
               alu_a1, alu_b1, alu_op1, rsp_valid1, busy1);
    end
    tick();
    checks++;
    if ({rsp_valid1, rsp_result1, rsp_zero1, rsp_err1} !== {1'b1, 8'd12, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_rsp got v=%b r=%0d z=%b e=%b exp v=1 r=12 z=0 e=0",
               rsp_valid1, rsp_result1, rsp_zero1, rsp_err1);
    end
    tick();
    checks++;
    if ({rsp_valid1, cmd_ready1} !== 2'b01) begin
      errors++; $display("FAIL add_done got v=%b rdy=%b exp v=0 rdy=1", rsp_valid1, cmd_ready1);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] ta [3] = '{8'd8, 8'd255, 8'd8};
    logic [7:0] tb [3] = '{8'd8, 8'd1, 8'd4};
    logic [2:0] top [3] = '{3'b001, 3'b000, 3'b101};
    logic [7:0] er [3] = '{8'h00, 8'h00, 8'hF3};
    logic       ez [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send1(ta[i], tb[i], top[i], 1'b0);
      tick();
      checks++;
      if ({rsp_valid1, rsp_result1, rsp_zero1, rsp_err1} !== {1'b1, er[i], ez[i], 1'b0}) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b r=%h z=%b e=%b exp v=1 r=%h z=%b e=0",
                 i, rsp_valid1, rsp_result1, rsp_zero1, rsp_err1, er[i], ez[i]);
      end
      tick();
    end
  endtask

  // Previous command was NOR 8,4: ALU inputs must keep those values.
  task automatic test_invalid;
    send1(8'd1, 8'd2, 3'b110, 1'b0);
    checks++;
    if ({rsp_valid1, rsp_err1, rsp_zero1, rsp_result1} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL invalid_rsp got v=%b e=%b z=%b r=%0d exp v=1 e=1 z=0 r=0",
               rsp_valid1, rsp_err1, rsp_zero1, rsp_result1);
    end
    checks++;
    if ({alu_op1, alu_a1, alu_b1} !== {3'b101, 8'd8, 8'd4}) begin
      errors++;
      $display("FAIL invalid_alu_hold got op=%0d a=%0d b=%0d exp op=5 a=8 b=4", alu_op1, alu_a1, alu_b1);
    end
    tick();
    checks++;
    if (cmd_ready1 !== 1'b1) begin
      errors++; $display("FAIL invalid_done got rdy=%b exp 1", cmd_ready1);
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    send1(8'd3, 8'd5, 3'b000, 1'b0);
    tick();
    cmd_a = 8'd1; cmd_b = 8'd1; cmd_op = 3'b000; c_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid1, rsp_result1, rsp_zero1, rsp_err1, cmd_ready1, busy1}
          !== {1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b r=%0d z=%b e=%b rdy=%b busy=%b exp v=1 r=8 z=0 e=0 rdy=0 busy=1",
                 i, rsp_valid1, rsp_result1, rsp_zero1, rsp_err1, cmd_ready1, busy1);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid1, cmd_ready1, alu_a1} !== {1'b0, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b a=%0d exp v=0 rdy=1 a=3", rsp_valid1, cmd_ready1, alu_a1);
    end
    tick();
    c_valid1 = 1'b0;
    checks++;
    if ({alu_a1, busy1} !== {8'd1, 1'b1}) begin
      errors++; $display("FAIL bp_next_accept got a=%0d busy=%b exp a=1 busy=1", alu_a1, busy1);
    end
    tick();
    checks++;
    if ({rsp_valid1, rsp_result1} !== {1'b1, 8'd2}) begin
      errors++; $display("FAIL bp_next_rsp got v=%b r=%0d exp v=1 r=2", rsp_valid1, rsp_result1);
    end
    tick();
  endtask

  task automatic test_settle;
    int lat = 0;
    send3(8'd10, 8'd20, 3'b000);
    while (rsp_valid3 !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL settle_latency got %0d exp 3", lat);
    end
    checks++;
    if ({rsp_result3, rsp_zero3, rsp_err3} !== {8'd30, 1'b0, 1'b0}) begin
      errors++; $display("FAIL settle_rsp got r=%0d z=%b e=%b exp r=30 z=0 e=0", rsp_result3, rsp_zero3, rsp_err3);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    logic [31:0] v3;
    logic        seen = 1'b0;
    send3(8'd1, 8'd1, 3'b000);
    tick();
    #2 rst_n = 1'b0;
    #1;
    v3 = {cmd_ready3, rsp_valid3, busy3, rsp_err3, rsp_zero3, rsp_result3, alu_a3, alu_b3, alu_op3};
    checks++;
    if (v3 !== 32'h8000_0000) begin
      errors++; $display("FAIL reset_mid_outputs got %h exp 80000000", v3);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid3 === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid_dropped got rsp_valid seen=%b exp 0", seen);
    end
  endtask

  task automatic test_chain;
    logic [7:0] exp_a, exp_r;
`ifdef RESULT_CHAIN_EN
    exp_a = 8'd12; exp_r = 8'd16;
`else
    exp_a = 8'd99; exp_r = 8'd103;
`endif
    send1(8'd8, 8'd4, 3'b000, 1'b0);
    tick();
    tick();
    send1(8'd99, 8'd4, 3'b000, 1'b1);
    checks++;
    if (alu_a1 !== exp_a) begin
      errors++; $display("FAIL chain_alu_a got %0d exp %0d", alu_a1, exp_a);
    end
    tick();
    checks++;
    if ({rsp_valid1, rsp_result1} !== {1'b1, exp_r}) begin
      errors++; $display("FAIL chain_rsp got v=%b r=%0d exp v=1 r=%0d", rsp_valid1, rsp_result1, exp_r);
    end
    tick();
    cmd_chain = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; c_valid1 = 1'b0; c_valid3 = 1'b0; rsp_ready = 1'b1;
    cmd_chain = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_add();
    test_wrap();
    test_invalid();
    test_backpressure();
    test_settle();
    test_reset_mid();
    test_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
